// File: rtl/call_stack_pkg.sv
// -----------------------------------------------------------------------------
// call_stack_pkg
// Shared types and helpers for the call/return stack slice:
//   - CS_CNT_W      : storage width of the per-context pointer/counter fields
//                     (supports DEPTH up to 2**CS_CNT_W - 1 entries)
//   - stack_op_e    : operation resolved by the top level for one context
//   - ctx_state_t   : per-context bookkeeping (wp, count, max_depth, err_sticky)
//   - depth_w_f     : width needed to hold 0..DEPTH
//   - ctx_w_f       : width of the context selector, never less than 1
// -----------------------------------------------------------------------------
package call_stack_pkg;

   localparam int CS_CNT_W = 8;

   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_PUSH    = 3'd1,
      OP_POP     = 3'd2,
      OP_REPLACE = 3'd3,
      OP_FLUSH   = 3'd4
   } stack_op_e;

   typedef struct packed {
      logic [CS_CNT_W-1:0] wp;
      logic [CS_CNT_W-1:0] count;
      logic [CS_CNT_W-1:0] max_depth;
      logic                err_sticky;
   } ctx_state_t;

   function automatic int depth_w_f(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ctx_w_f(input int num_ctx);
      if (num_ctx > 1) begin
         return $clog2(num_ctx);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/call_return_stack_if.sv
// -----------------------------------------------------------------------------
// call_return_stack_if
// Operation/status bundle of the call/return stack.
//   master : sequencer side, drives ctx/call_valid/call_addr/ret_valid/flush,
//            observes the selected context's status
//   slave  : the stack itself
// Parameters must agree with the stack instance:
//   CTX_W = max(1, clog2(NUM_CTX)), DEPTH_W = clog2(DEPTH+1)
// -----------------------------------------------------------------------------
interface call_return_stack_if #(
   parameter int ADDR_W  = 32,
   parameter int CTX_W   = 1,
   parameter int DEPTH_W = 4
);
   logic [CTX_W-1:0]   ctx;
   logic               call_valid;
   logic [ADDR_W-1:0]  call_addr;
   logic               ret_valid;
   logic               flush;
   logic               top_valid;
   logic [ADDR_W-1:0]  top_addr;
   logic [DEPTH_W-1:0] depth;
   logic [DEPTH_W-1:0] max_depth;
   logic               overflow;
   logic               underflow;
   logic               err_sticky;

   modport master (
      output ctx, call_valid, call_addr, ret_valid, flush,
      input  top_valid, top_addr, depth, max_depth, overflow, underflow, err_sticky
   );

   modport slave (
      input  ctx, call_valid, call_addr, ret_valid, flush,
      output top_valid, top_addr, depth, max_depth, overflow, underflow, err_sticky
   );
endinterface

// File: rtl/call_stack_ctx.sv
// -----------------------------------------------------------------------------
// call_stack_ctx
// Storage and pointer logic for one call/return stack context.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   op           : resolved operation for this context this cycle
//   call_addr    : address written by PUSH / REPLACE
//   top_valid    : context non-empty
//   top_addr     : entry[(wp-1) mod DEPTH], 0 when empty (combinational)
//   depth        : current entry count
//   max_depth    : high-water mark of depth since reset
//   err_sticky   : overflow/underflow seen since reset or flush
//   ovf_evt      : this cycle's PUSH hits a full stack (combinational)
//   udf_evt      : this cycle's POP hits an empty stack (combinational)
// Build option CALL_STACK_WRAP_EN: a PUSH to a full stack overwrites the
// oldest entry instead of being dropped.
// -----------------------------------------------------------------------------
module call_stack_ctx
   import call_stack_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 8,
   parameter int DEPTH_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  stack_op_e          op,
   input  logic [ADDR_W-1:0]  call_addr,
   output logic               top_valid,
   output logic [ADDR_W-1:0]  top_addr,
   output logic [DEPTH_W-1:0] depth,
   output logic [DEPTH_W-1:0] max_depth,
   output logic               err_sticky,
   output logic               ovf_evt,
   output logic               udf_evt
);

   ctx_state_t          state_r;
   ctx_state_t          next_s;
   logic [ADDR_W-1:0]   entry_r [DEPTH];
   logic                empty_s;
   logic                full_s;
   logic [CS_CNT_W-1:0] wp_inc_s;
   logic [CS_CNT_W-1:0] top_idx_s;
   logic [ADDR_W-1:0]   rd_addr_s;
   logic                wr_en_s;
   logic [CS_CNT_W-1:0] wr_idx_s;

   // Pointer helpers: occupancy flags and modulo-DEPTH neighbours of wp
   always_comb begin
      empty_s = (state_r.count == CS_CNT_W'(0));
      full_s  = (state_r.count >= CS_CNT_W'(DEPTH));
      if (state_r.wp == CS_CNT_W'(DEPTH - 1)) begin
         wp_inc_s = CS_CNT_W'(0);
      end else begin
         wp_inc_s = state_r.wp + CS_CNT_W'(1);
      end
      if (state_r.wp == CS_CNT_W'(0)) begin
         top_idx_s = CS_CNT_W'(DEPTH - 1);
      end else begin
         top_idx_s = state_r.wp - CS_CNT_W'(1);
      end
   end

   // Read mux for the top entry; a compare per slot keeps DEPTH arbitrary
   always_comb begin
      rd_addr_s = ADDR_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr_s = rd_addr_s | (entry_r[i] & {ADDR_W{top_idx_s == CS_CNT_W'(i)}});
      end
   end

   // Next-state decode for the resolved operation
   always_comb begin
      next_s   = state_r;
      wr_en_s  = 1'b0;
      wr_idx_s = state_r.wp;
      ovf_evt  = 1'b0;
      udf_evt  = 1'b0;
      case (op)
         OP_FLUSH: begin
            // wp is kept: only occupancy and the error flag are cleared
            next_s.count      = CS_CNT_W'(0);
            next_s.err_sticky = 1'b0;
         end
         OP_PUSH, OP_REPLACE: begin
            if ((op == OP_REPLACE) && !empty_s) begin
               // tail call: swap the return address in place
               wr_en_s  = 1'b1;
               wr_idx_s = top_idx_s;
            end else if (full_s) begin
               ovf_evt           = 1'b1;
               next_s.err_sticky = 1'b1;
`ifdef CALL_STACK_WRAP_EN
               // ring behaviour: newest DEPTH calls remain, count stays DEPTH
               wr_en_s   = 1'b1;
               next_s.wp = wp_inc_s;
`else
               next_s.wp = state_r.wp;
`endif
            end else begin
               wr_en_s      = 1'b1;
               next_s.wp    = wp_inc_s;
               next_s.count = state_r.count + CS_CNT_W'(1);
            end
         end
         OP_POP: begin
            if (empty_s) begin
               udf_evt           = 1'b1;
               next_s.err_sticky = 1'b1;
            end else begin
               next_s.wp    = top_idx_s;
               next_s.count = state_r.count - CS_CNT_W'(1);
            end
         end
         default: begin
            next_s = state_r;
         end
      endcase
      if (next_s.count > state_r.max_depth) begin
         next_s.max_depth = next_s.count;
      end else begin
         next_s.max_depth = state_r.max_depth;
      end
   end

   // Bookkeeping register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= '{wp: CS_CNT_W'(0), count: CS_CNT_W'(0),
                      max_depth: CS_CNT_W'(0), err_sticky: 1'b0};
      end else begin
         state_r <= next_s;
      end
   end

   // Entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en_s && (wr_idx_s == CS_CNT_W'(i))) begin
            entry_r[i] <= call_addr;
         end
      end
   end

   assign top_valid  = !empty_s;
   assign top_addr   = empty_s ? ADDR_W'(0) : rd_addr_s;
   assign depth      = state_r.count[DEPTH_W-1:0];
   assign max_depth  = state_r.max_depth[DEPTH_W-1:0];
   assign err_sticky = state_r.err_sticky;

endmodule

// File: rtl/call_return_stack.sv
// -----------------------------------------------------------------------------
// call_return_stack
// Call/return stack for NUM_CTX independent contexts. A call pushes a return
// address, a return pops one, both together replace the top (tail call),
// flush empties the selected context.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : call_return_stack_if.slave
//                ctx/call_valid/call_addr/ret_valid/flush in,
//                top_valid/top_addr/depth/max_depth/err_sticky out for the
//                selected context (combinational), overflow/underflow out as
//                registered one-cycle pulses
// Build option CALL_STACK_WRAP_EN: calls to a full stack overwrite the oldest
// entry instead of being dropped.
// -----------------------------------------------------------------------------
module call_return_stack
   import call_stack_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 8,
   parameter int NUM_CTX = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   call_return_stack_if.slave  bus
);

   localparam int CTX_W   = ctx_w_f(NUM_CTX);
   localparam int DEPTH_W = depth_w_f(DEPTH);

   logic [NUM_CTX-1:0] sel_s;
   stack_op_e          op_res_s;
   stack_op_e          op_a [NUM_CTX];
   logic [NUM_CTX-1:0] top_valid_a;
   logic [ADDR_W-1:0]  top_addr_a [NUM_CTX];
   logic [DEPTH_W-1:0] depth_a [NUM_CTX];
   logic [DEPTH_W-1:0] max_depth_a [NUM_CTX];
   logic [NUM_CTX-1:0] err_a;
   logic [NUM_CTX-1:0] ovf_a;
   logic [NUM_CTX-1:0] udf_a;

   logic               sel_top_valid_s;
   logic [ADDR_W-1:0]  sel_top_addr_s;
   logic [DEPTH_W-1:0] sel_depth_s;
   logic [DEPTH_W-1:0] sel_max_depth_s;
   logic               sel_err_s;
   logic               overflow_r;
   logic               underflow_r;

   // One-hot context decode and AND-OR output mux; an out-of-range ctx
   // selects nothing and reads as an idle, empty context
   always_comb begin
      sel_s           = {NUM_CTX{1'b0}};
      sel_top_valid_s = 1'b0;
      sel_top_addr_s  = ADDR_W'(0);
      sel_depth_s     = DEPTH_W'(0);
      sel_max_depth_s = DEPTH_W'(0);
      sel_err_s       = 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
         sel_s[i]        = (bus.ctx == CTX_W'(i));
         sel_top_valid_s = sel_top_valid_s | (top_valid_a[i] & sel_s[i]);
         sel_top_addr_s  = sel_top_addr_s  | (top_addr_a[i]  & {ADDR_W{sel_s[i]}});
         sel_depth_s     = sel_depth_s     | (depth_a[i]     & {DEPTH_W{sel_s[i]}});
         sel_max_depth_s = sel_max_depth_s | (max_depth_a[i] & {DEPTH_W{sel_s[i]}});
         sel_err_s       = sel_err_s       | (err_a[i] & sel_s[i]);
      end
   end

   // Operation priority: flush > tail call > call > return. A tail call on an
   // empty stack degenerates to a plain push so it never underflows.
   always_comb begin
      op_res_s = OP_NOP;
      if (bus.flush) begin
         op_res_s = OP_FLUSH;
      end else if (bus.call_valid && bus.ret_valid) begin
         if (sel_depth_s == DEPTH_W'(0)) begin
            op_res_s = OP_PUSH;
         end else begin
            op_res_s = OP_REPLACE;
         end
      end else if (bus.call_valid) begin
         op_res_s = OP_PUSH;
      end else if (bus.ret_valid) begin
         op_res_s = OP_POP;
      end else begin
         op_res_s = OP_NOP;
      end
   end

   // Steer the resolved operation to the selected context only
   always_comb begin
      for (int i = 0; i < NUM_CTX; i++) begin
         op_a[i] = sel_s[i] ? op_res_s : OP_NOP;
      end
   end

   for (genvar g = 0; g < NUM_CTX; g++) begin : g_ctx
      call_stack_ctx #(
         .ADDR_W  (ADDR_W),
         .DEPTH   (DEPTH),
         .DEPTH_W (DEPTH_W)
      ) u_ctx (
         .clk        (clk),
         .rst_n      (rst_n),
         .op         (op_a[g]),
         .call_addr  (bus.call_addr),
         .top_valid  (top_valid_a[g]),
         .top_addr   (top_addr_a[g]),
         .depth      (depth_a[g]),
         .max_depth  (max_depth_a[g]),
         .err_sticky (err_a[g]),
         .ovf_evt    (ovf_a[g]),
         .udf_evt    (udf_a[g])
      );
   end

   // Error pulses appear the cycle after the offending operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         overflow_r  <= |ovf_a;
         underflow_r <= |udf_a;
      end
   end

   assign bus.top_valid  = sel_top_valid_s;
   assign bus.top_addr   = sel_top_addr_s;
   assign bus.depth      = sel_depth_s;
   assign bus.max_depth  = sel_max_depth_s;
   assign bus.err_sticky = sel_err_s;
   assign bus.overflow   = overflow_r;
   assign bus.underflow  = underflow_r;

endmodule

// File: doc/call_return_stack.md
# call_return_stack

Parametrised hardware call/return stack that tracks a function-call hierarchy for up to NUM_CTX independent contexts. Call events push a return address and return events pop one. A call and a return in the same cycle form a tail call. It sits beside the instruction-sequencing logic and feeds the predicted return address, current depth and overflow/underflow status to the trace and debug units.

## Interface
- ADDR_W, 32, width of a stored return address
- DEPTH, 8, entries per context (≥2)
- NUM_CTX, 1, number of independent stacks (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ctx  in  CTX_W  context selected for this cycle's operation and outputs; CTX_W = max(1,$clog2(NUM_CTX))
- call_valid  in  1  push call_addr onto stack ctx
- call_addr  in  ADDR_W  return address to push
- ret_valid  in  1  pop top of stack ctx
- flush  in  1  empty stack ctx
- top_valid  out  1  stack ctx non-empty
- top_addr  out  ADDR_W  top entry of stack ctx; 0 when empty
- depth  out  DEPTH_W  entries in stack ctx; DEPTH_W = $clog2(DEPTH+1)
- max_depth  out  DEPTH_W  high-water mark of stack ctx since reset
- overflow  out  1  one-cycle pulse: call to a full stack
- underflow  out  1  one-cycle pulse: return from an empty stack
- err_sticky  out  1  stack ctx has seen overflow or underflow since reset or flush

## Operation
- Per context: entry array DEPTH×ADDR_W, write pointer wp (0..DEPTH-1, wraps modulo DEPTH), count (0..DEPTH), max_depth, err_sticky.
- Top entry = entry[(wp-1) mod DEPTH]. Outputs for the selected context are combinational from registered state.
- Priority for the selected context: flush > tail call > call > return. Unselected contexts never change.
- flush: count←0, err_sticky←0. wp and max_depth are unchanged. No pulses. Any call/ret in the same cycle is ignored.
- Call only, count<DEPTH: entry[wp]←call_addr, wp←wp+1, count←count+1.
- Call only, count==DEPTH: behaviour depends on CALL_STACK_WRAP_EN (see Configuration). In both modes overflow pulses and err_sticky←1.
- Return only, count>0: wp←wp-1, count←count-1. The popped value is top_addr in that same cycle.
- Return only, count==0: no state change, underflow pulses, err_sticky←1.
- Call and return together (tail call):
  - count>0: overwrite top entry with call_addr; count and wp unchanged; no pulses.
  - count==0: treated as a plain call (push); no underflow.
- max_depth←max(max_depth, next count) every cycle.

## Timing
- All state updates on the rising clk edge where the operation is sampled; new depth/top visible the next cycle.
- Zero-latency read path: a return's address is on top_addr in the same cycle as ret_valid.
- overflow/underflow are registered: they assert the cycle after the offending operation and last exactly one cycle.
- No backpressure: an operation is accepted every cycle, including back-to-back operations on the same or different contexts.
- Reset (any time, including mid-sequence): every count, wp, max_depth and err_sticky goes to 0, and overflow/underflow go to 0. Entry contents need no reset. Outputs after reset: top_valid=0, top_addr=0, depth=0.

## Configuration
- CALL_STACK_WRAP_EN defined: a call to a full stack overwrites the oldest entry. entry[wp]←call_addr, wp←wp+1, count stays DEPTH. The newest DEPTH calls stay retrievable.
- CALL_STACK_WRAP_EN undefined: a call to a full stack is dropped and state is unchanged (saturate).
- The overflow pulse and err_sticky behave identically in both modes.

## Structure
- Shared package call_stack_pkg holds:
  - a typedef for the per-context state struct (wp, count, max_depth, err_sticky);
  - a function computing DEPTH_W;
  - an enum for the resolved operation (NOP, PUSH, POP, REPLACE, FLUSH).
- One sub-module, call_stack_ctx: the storage and pointer logic for a single context, taking the resolved operation. The top level instantiates NUM_CTX copies, decodes ctx and call/ret/flush into per-context operations, and muxes the outputs.

## Test plan
- DEPTH=8. Push 0x100,0x200,0x300; then three returns → top_addr 0x300,0x200,0x100 on the return cycles; depth 3→0; max_depth=3; no pulses.
- Return on an empty stack → underflow high exactly one cycle; err_sticky=1; depth stays 0. Then flush → err_sticky=0.
- Push 9 addresses 0x1..0x9:
  - without CALL_STACK_WRAP_EN: overflow pulses once, depth=8, top_addr=0x8;
  - with it: overflow pulses once, depth=8, top_addr=0x9; after 8 returns the last popped value is 0x2.
- Push 0xA, then call+ret together with call_addr 0xB → depth 1, top_addr 0xB. Call+ret on an empty stack → depth 1, no underflow.
- NUM_CTX=4. Interleave pushes to ctx 0 and ctx 2 → each context's depth and top are independent; ctx 1 and ctx 3 stay at depth 0.
- Assert rst_n low mid-sequence at depth 5 → asynchronously depth=0, top_valid=0, max_depth=0, no pulse after release.
